// File: rtl/ssbr_serial_feeder.sv
// Serial feeder for the SSBR shift register: takes a parallel word on a valid/ready
// handshake, sends it bit by bit on D, then sends WIDTH flush zeros. Optional parity bit: FEEDER_PARITY_EN.
module ssbr_serial_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             dir_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             D,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // state    | meaning
  // S_IDLE   | waiting for a handshake, D held at 0
  // S_SHIFT  | data bits on D, one per cycle
  // S_PARITY | even-parity bit on D (parity build only)
  // S_FLUSH  | WIDTH zero bits pushing the word out of the register
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_FLUSH} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic             r_d;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
`ifdef FEEDER_PARITY_EN
  logic             r_par;
`endif

  logic             w_hs;
  logic             w_last;
  logic             w_first;
  logic [WIDTH-1:0] w_rest;
  logic             w_shift_bit;
  logic [WIDTH-1:0] w_sh_next;

  assign in_ready    = (r_state == S_IDLE) & ~rst;
  assign w_hs        = in_valid & in_ready;
  assign w_last      = (r_cnt == LAST);
  // r_sh holds the bits still to be sent; the next one always sits at the leading end
  assign w_first     = dir_in ? word_in[0] : word_in[WIDTH-1];
  assign w_rest      = dir_in ? (word_in >> 1) : (word_in << 1);
  assign w_shift_bit = r_dir ? r_sh[0] : r_sh[WIDTH-1];
  assign w_sh_next   = r_dir ? (r_sh >> 1) : (r_sh << 1);

  assign D    = r_d;
  assign dir  = r_dir;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_d     <= 1'b0;
      r_dir   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FEEDER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_cnt  <= '0;
          if (w_hs) begin
            r_state <= S_SHIFT;
            r_d     <= w_first;
            r_sh    <= w_rest;
            r_dir   <= dir_in;
            r_busy  <= 1'b1;
`ifdef FEEDER_PARITY_EN
            r_par   <= ^word_in;
`endif
          end else begin
            r_d <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            r_cnt <= '0;
`ifdef FEEDER_PARITY_EN
            r_state <= S_PARITY;
            r_d     <= r_par;
`else
            r_state <= S_FLUSH;
            r_d     <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_d   <= w_shift_bit;
            r_sh  <= w_sh_next;
          end
        end
        S_PARITY: begin
          r_state <= S_FLUSH;
          r_d     <= 1'b0;
          r_cnt   <= '0;
        end
        S_FLUSH: begin
          r_d <= 1'b0;
          if (w_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_d     <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssbr_serial_feeder.sv
// Bench for ssbr_serial_feeder: word-level reference model checked every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_ssbr_serial_feeder;

  localparam int W = 4;
`ifdef FEEDER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LEN = 2 * W + P;  // busy cycles per word
  localparam int DN  = LEN + 1;    // cycle of the done pulse

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] word_in = '0;
  logic         dir_in = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready, D, dir, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ssbr_serial_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .dir_in(dir_in), .in_valid(in_valid),
    .in_ready(in_ready), .D(D), .dir(dir), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position within the current word, counted in cycles since handshake.
  int           m_t = 0;
  logic [W-1:0] m_word = '0;
  logic         m_wdir = 1'b1;
  logic         m_dirout = 1'b1;
  logic         m_done = 1'b0;
  bit           m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_live   <= 1'b1;
      m_t      <= 0;
      m_done   <= 1'b0;
      m_dirout <= 1'b1;
    end else if (m_t == 0) begin
      m_done <= 1'b0;
      if (in_valid) begin
        m_t      <= 1;
        m_word   <= word_in;
        m_wdir   <= dir_in;
        m_dirout <= dir_in;
      end
    end else if (m_t == LEN) begin
      m_t    <= 0;
      m_done <= 1'b1;
    end else begin
      m_t    <= m_t + 1;
      m_done <= 1'b0;
    end
  end

  function automatic logic exp_d(input int t, input logic [W-1:0] w, input logic d);
    logic [W-1:0] s;
    if (t >= 1 && t <= W) begin
      s = d ? (w >> (t - 1)) : (w >> (W - t));
      return s[0];
    end
    if (P == 1 && t == W + 1) return ^w;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_D", D, exp_d(m_t, m_word, m_wdir));
      chk("model_dir", dir, m_dirout);
      chk("model_busy", busy, m_t != 0);
      chk("model_done", done, m_done);
      chk("model_in_ready", in_ready, (m_t == 0) && !rst);
    end
  end

  // Per-cycle capture for the directed literal checks; index = cycles after handshake.
  logic cap_d[0:40], cap_dir[0:40], cap_busy[0:40], cap_done[0:40], cap_rdy[0:40];

  function automatic int count_hi(input int sel, input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) begin
      if (sel == 0 && cap_done[i]) c++;
      if (sel == 1 && cap_rdy[i]) c++;
      if (sel == 2 && cap_dir[i]) c++;
    end
    return c;
  endfunction

  // Handshake in cycle 0, then run n cycles with optional hold/second handshake/reset.
  task automatic run(input logic [W-1:0] w1, input logic d1, input int n, input int hold_to,
                     input int hs2_at, input logic [W-1:0] w2, input logic d2, input int rst_at);
    for (int k = 0; k <= n; k++) begin
      in_valid = (k == 0) || (k <= hold_to) || (k == hs2_at);
      word_in  = (k == 0) ? w1 : (k == hs2_at) ? w2 : W'($urandom);
      dir_in   = (k == 0) ? d1 : (k == hs2_at) ? d2 : 1'($urandom);
      rst      = (k == rst_at);
      if (k > 0) begin
        @(negedge clk);
        cap_d[k] = D; cap_dir[k] = dir; cap_busy[k] = busy;
        cap_done[k] = done; cap_rdy[k] = in_ready;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  logic [3:0] e;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_D", D, 0);
    chk("rst_dir", dir, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // word 0100 LSB first
    run(4'b0100, 1'b1, 11, -1, -1, 4'b0, 1'b0, -1);
    e = 4'b0010;
    for (int i = 1; i <= 4; i++) chk($sformatf("t1_d%0d", i), cap_d[i], e[4-i]);
`ifndef FEEDER_PARITY_EN
    for (int i = 5; i <= 8; i++) chk($sformatf("t1_flush%0d", i), cap_d[i], 0);
`endif
    chk("t1_done_before", cap_done[DN-1], 0);
    chk("t1_done", cap_done[DN], 1);
    chk("t1_done_after", cap_done[DN+1], 0);
    chk("t1_done_count", count_hi(0, 1, 11), 1);
    chk("t1_dir_held", count_hi(2, 1, 11), 11);

    // word 0100 MSB first
    run(4'b0100, 1'b0, 11, -1, -1, 4'b0, 1'b0, -1);
    e = 4'b0100;
    for (int i = 1; i <= 4; i++) chk($sformatf("t2_d%0d", i), cap_d[i], e[4-i]);
    chk("t2_dir_c1", cap_dir[1], 0);
    chk("t2_dir_after_done", cap_dir[11], 0);

    // back-to-back: second handshake in the done cycle
    run(4'b1011, 1'b1, 2 * DN + 1, -1, DN, 4'b0001, 1'b0, -1);
    e = 4'b1101;
    for (int i = 1; i <= 4; i++) chk($sformatf("t3_d%0d", i), cap_d[i], e[4-i]);
    chk("t3_done1", cap_done[DN], 1);
    chk("t3_dir_in_done", cap_dir[DN], 1);
    chk("t3_dir_flip", cap_dir[DN+1], 0);
    chk("t3_d_second_first", cap_d[DN+1], 0);
    chk("t3_d_second_last", cap_d[DN+4], 1);
    chk("t3_busy_no_gap", cap_busy[DN+1], 1);
    chk("t3_done2", cap_done[2*DN], 1);
    chk("t3_done_count", count_hi(0, 1, 2 * DN + 1), 2);

    // in_valid held high with churning word_in while busy
    run(4'b1101, 1'b1, DN + 3, LEN, -1, 4'b0, 1'b0, -1);
    e = 4'b1011;
    for (int i = 1; i <= 4; i++) chk($sformatf("t4_d%0d", i), cap_d[i], e[4-i]);
    chk("t4_ready_while_busy", count_hi(1, 1, LEN), 0);
    chk("t4_done", cap_done[DN], 1);
    chk("t4_done_count", count_hi(0, 1, DN + 3), 1);

    // reset in cycle 3 aborts the word
    run(4'b1111, 1'b0, 8, -1, -1, 4'b0, 1'b0, 3);
    chk("t5_busy_c3", cap_busy[3], 1);
    chk("t5_d_c4", cap_d[4], 0);
    chk("t5_dir_c4", cap_dir[4], 1);
    chk("t5_busy_c4", cap_busy[4], 0);
    chk("t5_done_c4", cap_done[4], 0);
    chk("t5_ready_c4", cap_rdy[4], 1);
    chk("t5_no_done", count_hi(0, 1, 8), 0);

`ifdef FEEDER_PARITY_EN
    run(4'b0111, 1'b1, 11, -1, -1, 4'b0, 1'b0, -1);
    e = 4'b1110;
    for (int i = 1; i <= 4; i++) chk($sformatf("t6_d%0d", i), cap_d[i], e[4-i]);
    chk("t6_parity", cap_d[5], 1);
    for (int i = 6; i <= 9; i++) chk($sformatf("t6_flush%0d", i), cap_d[i], 0);
    chk("t6_done", cap_done[10], 1);
    chk("t6_done_count", count_hi(0, 1, 11), 1);
`endif

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      word_in  = W'($urandom);
      dir_in   = 1'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2 * DN) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
